rtc_rd_seq: RTL

RTC_RD_SEQ -- requirements
Module: rtc_rd_seq

---
 rtl/rtc_rd_seq_if.sv | 20 ++
 rtl/rtc_rd_seq.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/rtc_rd_seq_if.sv
// Multiplexed address/data bus and strobes between the read sequencer and the RTC chip.
interface rtc_rd_seq_if;
    logic [7:0] ad_in;
    logic [7:0] ad_out;
    logic       ad_oe;
    logic       cs_n;
    logic       as_n;
    logic       rd_n;
    logic       wr_n;

    modport master (
        input  ad_in,
        output ad_out, ad_oe, cs_n, as_n, rd_n, wr_n
    );

    modport slave (
        output ad_in,
        input  ad_out, ad_oe, cs_n, as_n, rd_n, wr_n
    );
endinterface

// File: rtl/rtc_rd_seq.sv
// Reads seconds..year (RTC registers 0x21..0x26) over a multiplexed bus and
// pulses one load enable per field with the captured byte on dseg.
module rtc_rd_seq #(
    parameter int T_PH = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    rtc_rd_seq_if.master        bus,
    output logic [7:0]          dseg,
    output logic                en_seg,
    output logic                en_min,
    output logic                en_hora,
    output logic                en_dia,
    output logic                en_mes,
    output logic                en_anio,
    output logic                busy,
    output logic                done
);

    typedef enum logic [2:0] {IDLE, ADDR, GAP, DATA, CAP, RECOV} state_t;

    localparam logic [7:0] PH_LAST    = 8'(T_PH - 1);
    localparam logic [7:0] FIRST_ADDR = 8'h21;

    // Initial values give the reset state at power-up as well.
    state_t     state_reg  = IDLE;
    logic [7:0] cnt_reg    = 8'h00;
    logic [2:0] idx_reg    = 3'd0;
    logic [7:0] ad_out_reg = 8'h00;
    logic       ad_oe_reg  = 1'b0;
    logic       cs_n_reg   = 1'b1;
    logic       as_n_reg   = 1'b1;
    logic       rd_n_reg   = 1'b1;
    logic       wr_n_reg   = 1'b1;
    logic [7:0] dseg_reg   = 8'h00;
    logic [5:0] en_reg     = 6'd0;
    logic       busy_reg   = 1'b0;
    logic       done_reg   = 1'b0;

    logic       ph_last;
    logic [2:0] idx_inc;

    assign ph_last = (cnt_reg == PH_LAST);
    assign idx_inc = idx_reg + 3'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= IDLE;
            cnt_reg    <= 8'h00;
            idx_reg    <= 3'd0;
            ad_out_reg <= 8'h00;
            ad_oe_reg  <= 1'b0;
            cs_n_reg   <= 1'b1;
            as_n_reg   <= 1'b1;
            rd_n_reg   <= 1'b1;
            wr_n_reg   <= 1'b1;
            dseg_reg   <= 8'h00;
            en_reg     <= 6'd0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            en_reg   <= 6'd0;
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        state_reg  <= ADDR;
                        cnt_reg    <= 8'h00;
                        idx_reg    <= 3'd0;
                        busy_reg   <= 1'b1;
                        ad_out_reg <= FIRST_ADDR;
                        ad_oe_reg  <= 1'b1;
                        cs_n_reg   <= 1'b0;
                        as_n_reg   <= 1'b0;
                        wr_n_reg   <= 1'b0;
                        rd_n_reg   <= 1'b1;
                    end
                end
                ADDR: begin
                    if (ph_last) begin
                        state_reg <= GAP;
                        cnt_reg   <= 8'h00;
                        ad_oe_reg <= 1'b0;
                        cs_n_reg  <= 1'b1;
                        as_n_reg  <= 1'b1;
                        wr_n_reg  <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg + 8'd1;
                    end
                end
                GAP: begin
                    if (ph_last) begin
                        state_reg <= DATA;
                        cnt_reg   <= 8'h00;
                        cs_n_reg  <= 1'b0;
                        rd_n_reg  <= 1'b0;
                    end else begin
                        cnt_reg <= cnt_reg + 8'd1;
                    end
                end
                DATA: begin
                    // Byte is latched on the last read cycle so it is stable for all of CAP.
                    if (ph_last) begin
                        state_reg <= CAP;
                        cnt_reg   <= 8'h00;
                        dseg_reg  <= bus.ad_in;
                        en_reg    <= 6'd1 << idx_reg;
                        cs_n_reg  <= 1'b1;
                        rd_n_reg  <= 1'b1;
                    end else begin
                        cnt_reg <= cnt_reg + 8'd1;
                    end
                end
                CAP: begin
                    state_reg <= RECOV;
                    cnt_reg   <= 8'h00;
                end
                RECOV: begin
                    if (ph_last) begin
                        cnt_reg <= 8'h00;
                        if (idx_reg == 3'd5) begin
                            state_reg <= IDLE;
                            busy_reg  <= 1'b0;
                            done_reg  <= 1'b1;
                        end else begin
                            state_reg  <= ADDR;
                            idx_reg    <= idx_inc;
                            ad_out_reg <= FIRST_ADDR + {5'd0, idx_inc};
                            ad_oe_reg  <= 1'b1;
                            cs_n_reg   <= 1'b0;
                            as_n_reg   <= 1'b0;
                            wr_n_reg   <= 1'b0;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + 8'd1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign bus.ad_out = ad_out_reg;
    assign bus.ad_oe  = ad_oe_reg;
    assign bus.cs_n   = cs_n_reg;
    assign bus.as_n   = as_n_reg;
    assign bus.rd_n   = rd_n_reg;
    assign bus.wr_n   = wr_n_reg;

    assign dseg    = dseg_reg;
    assign en_seg  = en_reg[0];
    assign en_min  = en_reg[1];
    assign en_hora = en_reg[2];
    assign en_dia  = en_reg[3];
    assign en_mes  = en_reg[4];
    assign en_anio = en_reg[5];
    assign busy    = busy_reg;
    assign done    = done_reg;

endmodule
